elevator_ctrl: RTL and testbench

Parametrised, call-latching elevator controller for an N-floor car, the next-generation car controller in the elevator design. Registers floor calls until served and schedules them with SCAN (keep direction while calls remain ahead). Times floor-to-floor travel and door dwell with internal counters and drives door and motor command outputs plus the current floor index. Sits between the call-button and door-button debouncers and the motor/door actuator drivers.

---
 rtl/elevator_pkg.sv | 11 +
 rtl/elevator_call_reg.sv | 43 ++++
 rtl/elevator_ctrl.sv | 142 ++++++++++++++
 tb/tb_elevator_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state encoding, default sizing and one-hot output decode for the elevator car
package elevator_pkg;
    typedef enum logic [2:0] {IDLE, UP, DOWN, OPEN, CLOSE} state_t;
    localparam int DEF_N_FLOORS    = 8;
    localparam int DEF_MOVE_CYCLES = 4;
    localparam int DEF_DOOR_CYCLES = 6;
    // {open, close, up, down}; IDLE decodes to all zeros
    function automatic logic [3:0] state_oh(state_t s);
        return {s == OPEN, s == CLOSE, s == UP, s == DOWN};
    endfunction
endpackage

// File: rtl/elevator_call_reg.sv
// elevator_call_reg: per-floor call latch with clear-wins priority and direction search
// Ports: clk/rst async active-high; i_call_req call pulses; i_floor current floor;
// i_mask_here suppresses latching of the current floor; i_clr_en/i_clr_floor clear one call;
// o_calls_pending latched calls; o_here/o_any_above/o_any_below relative to i_floor.
module elevator_call_reg
    import elevator_pkg::*;
#(
    parameter int N_FLOORS = DEF_N_FLOORS,
    localparam int FW = $clog2(N_FLOORS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] i_call_req,
    input  logic [FW-1:0]       i_floor,
    input  logic                i_mask_here,
    input  logic                i_clr_en,
    input  logic [FW-1:0]       i_clr_floor,
    output logic [N_FLOORS-1:0] o_calls_pending,
    output logic                o_here,
    output logic                o_any_above,
    output logic                o_any_below
);
    logic [N_FLOORS-1:0] r_calls, w_set, w_clr;
    always_comb begin
        w_set = i_call_req;
        w_clr = '0;
        if (i_mask_here) w_set[i_floor] = 1'b0;
        if (i_clr_en) w_clr[i_clr_floor] = 1'b1;
        o_any_above = 1'b0;
        o_any_below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (FW'(i) > i_floor) o_any_above = o_any_above | r_calls[i];
            if (FW'(i) < i_floor) o_any_below = o_any_below | r_calls[i];
        end
    end
    // clear is applied after set so a same-cycle set/clear leaves the bit low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_calls <= '0;
        else r_calls <= (r_calls | w_set) & ~w_clr;
    end
    assign o_calls_pending = r_calls;
    assign o_here = r_calls[i_floor];
endmodule

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: SCAN-scheduled, call-latching elevator car controller
// Ports: clk/rst async active-high; call_req per-floor call pulses; door_open_btn /
// door_close_btn door buttons; overload holds the door (only when ELEV_OVERLOAD_EN is defined);
// open/close/up/down registered one-hot state (all low in IDLE); floor current index;
// dir scan direction (1 = up); calls_pending latched unserved calls.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int N_FLOORS    = DEF_N_FLOORS,
    parameter int MOVE_CYCLES = DEF_MOVE_CYCLES,
    parameter int DOOR_CYCLES = DEF_DOOR_CYCLES,
    localparam int FW = $clog2(N_FLOORS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] call_req,
    input  logic                door_open_btn,
    input  logic                door_close_btn,
`ifdef ELEV_OVERLOAD_EN
    input  logic                overload,
`endif
    output logic                open,
    output logic                close,
    output logic                up,
    output logic                down,
    output logic [FW-1:0]       floor,
    output logic                dir,
    output logic [N_FLOORS-1:0] calls_pending
);
    localparam int MW = $clog2(MOVE_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    state_t        r_state;
    logic [3:0]    r_oh;
    logic [FW-1:0] r_floor;
    logic          r_dir;
    logic [MW-1:0] r_move;
    logic [DW-1:0] r_dwell;
    logic          w_here, w_above, w_below, w_arrive, w_next_pend, w_at_bound, w_ovl, w_open_entry;
    logic [FW-1:0] w_next_floor;
`ifdef ELEV_OVERLOAD_EN
    assign w_ovl = overload;
`else
    assign w_ovl = 1'b0;
`endif
    assign w_arrive     = (r_state == UP || r_state == DOWN) && r_move == MW'(MOVE_CYCLES - 1);
    assign w_next_floor = (r_state == UP) ? r_floor + 1'b1 : r_floor - 1'b1;
    assign w_next_pend  = calls_pending[w_next_floor];
    assign w_at_bound   = (r_state == UP) ? w_next_floor == FW'(N_FLOORS - 1) : w_next_floor == '0;
    // every transition into OPEN clears the call of the floor the door opens on
    assign w_open_entry = (w_arrive && w_next_pend)
                        || (door_open_btn && (r_state == IDLE || r_state == CLOSE))
                        || (r_state == IDLE && w_here);

    elevator_call_reg #(.N_FLOORS(N_FLOORS)) u_calls (
        .clk             (clk),
        .rst             (rst),
        .i_call_req      (call_req),
        .i_floor         (r_floor),
        .i_mask_here     (r_state == OPEN),
        .i_clr_en        (w_open_entry),
        .i_clr_floor     (w_arrive ? w_next_floor : r_floor),
        .o_calls_pending (calls_pending),
        .o_here          (w_here),
        .o_any_above     (w_above),
        .o_any_below     (w_below)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_oh    <= '0;
            r_floor <= '0;
            r_dir   <= 1'b1;
            r_move  <= '0;
            r_dwell <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_move  <= '0;
                    r_dwell <= '0;
                    if (door_open_btn || w_here) begin
                        r_state <= OPEN;
                        r_oh    <= state_oh(OPEN);
                    end else if (r_dir && w_above) begin
                        r_state <= UP;
                        r_oh    <= state_oh(UP);
                    end else if (w_below) begin
                        r_state <= DOWN;
                        r_oh    <= state_oh(DOWN);
                        r_dir   <= 1'b0;
                    end else if (w_above) begin
                        r_state <= UP;
                        r_oh    <= state_oh(UP);
                        r_dir   <= 1'b1;
                    end
                end
                UP, DOWN: begin
                    if (w_arrive) begin
                        r_move  <= '0;
                        r_floor <= w_next_floor;
                        if (w_next_pend) begin
                            r_state <= OPEN;
                            r_oh    <= state_oh(OPEN);
                        end else if (w_at_bound) begin
                            r_state <= IDLE;
                            r_oh    <= state_oh(IDLE);
                        end
                    end else begin
                        r_move <= r_move + 1'b1;
                    end
                end
                OPEN: begin
                    // overload freezes dwell and masks the close button; a call for this
                    // floor or the open button restarts dwell and beats the close button
                    if (w_ovl) begin
                        r_dwell <= r_dwell;
                    end else if (door_open_btn || call_req[r_floor]) begin
                        r_dwell <= '0;
                    end else if (door_close_btn || r_dwell == DW'(DOOR_CYCLES - 1)) begin
                        r_dwell <= '0;
                        r_state <= CLOSE;
                        r_oh    <= state_oh(CLOSE);
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                CLOSE: begin
                    r_state <= door_open_btn ? OPEN : IDLE;
                    r_oh    <= state_oh(door_open_btn ? OPEN : IDLE);
                end
                default: begin
                    r_state <= IDLE;
                    r_oh    <= '0;
                end
            endcase
        end
    end

    assign {open, close, up, down} = r_oh;
    assign floor = r_floor;
    assign dir   = r_dir;
endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: scoreboard bench; stimulus queues expected output segments, a monitor checks them
module tb_elevator_ctrl;
    typedef struct packed {
        logic [3:0] oh;
        logic [2:0] fl;
        logic       d;
        logic [7:0] p;
    } tup_t;
    typedef struct {
        tup_t t;
        int   len;
    } exp_t;

    localparam logic [3:0] SI = 4'b0000, SO = 4'b1000, SC = 4'b0100, SU = 4'b0010, SD = 4'b0001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] call_req = '0;
    logic       door_open_btn = 1'b0;
    logic       door_close_btn = 1'b0;
`ifdef ELEV_OVERLOAD_EN
    logic       overload = 1'b0;
`endif
    logic       open, close, up, down, dir;
    logic [2:0] floor;
    logic [7:0] calls_pending;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   flush = 0;
    bit   flushed = 0;

    always #5 clk = ~clk;

    elevator_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .call_req       (call_req),
        .door_open_btn  (door_open_btn),
        .door_close_btn (door_close_btn),
`ifdef ELEV_OVERLOAD_EN
        .overload       (overload),
`endif
        .open           (open),
        .close          (close),
        .up             (up),
        .down           (down),
        .floor          (floor),
        .dir            (dir),
        .calls_pending  (calls_pending)
    );

    task automatic ex(input logic [3:0] oh, input int fl, input logic d, input logic [7:0] p, input int len);
        exp_t e;
        e.t.oh = oh;
        e.t.fl = 3'(fl);
        e.t.d  = d;
        e.t.p  = p;
        e.len  = len;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] c, input logic ob, input logic cb);
        call_req = c;
        door_open_btn = ob;
        door_close_btn = cb;
        @(posedge clk);
        #1;
        call_req = '0;
        door_open_btn = 1'b0;
        door_close_btn = 1'b0;
    endtask

    // monitor: a segment is a run of cycles with a constant output tuple
    initial begin
        tup_t prev, cur;
        int cnt, seg;
        exp_t e;
        seg = 0;
        wait (!rst);
        @(negedge clk);
        prev = {open, close, up, down, floor, dir, calls_pending};
        cnt = 1;
        forever begin
            @(negedge clk);
            cur = {open, close, up, down, floor, dir, calls_pending};
            if (cur != prev || flush) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL seg%0d unexpected: got oh=%b fl=%0d dir=%0d pend=%h len=%0d, none queued",
                             seg, prev.oh, prev.fl, prev.d, prev.p, cnt);
                end else begin
                    e = q.pop_front();
                    if (e.t != prev || (e.len != 0 && e.len != cnt)) begin
                        failures++;
                        $display("FAIL seg%0d: got oh=%b fl=%0d dir=%0d pend=%h len=%0d, exp oh=%b fl=%0d dir=%0d pend=%h len=%0d",
                                 seg, prev.oh, prev.fl, prev.d, prev.p, cnt, e.t.oh, e.t.fl, e.t.d, e.t.p, e.len);
                    end
                end
                seg++;
                prev = cur;
                cnt = 1;
                if (flush) begin
                    flush = 0;
                    flushed = 1;
                end
            end else begin
                cnt++;
            end
        end
    end

    initial begin
        ex(SI, 0, 1, 8'h00, 0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(2);
        // single call to floor 3
        ex(SI, 0, 1, 8'h08, 1); ex(SU, 0, 1, 8'h08, 4); ex(SU, 1, 1, 8'h08, 4); ex(SU, 2, 1, 8'h08, 4);
        ex(SO, 3, 1, 8'h00, 6); ex(SC, 3, 1, 8'h00, 1); ex(SI, 3, 1, 8'h00, 0);
        pulse(8'h08, 0, 0); wait_cyc(30);
        // up one floor to 4
        ex(SI, 3, 1, 8'h10, 1); ex(SU, 3, 1, 8'h10, 4); ex(SO, 4, 1, 8'h00, 6); ex(SC, 4, 1, 8'h00, 1);
        ex(SI, 4, 1, 8'h00, 0);
        pulse(8'h10, 0, 0); wait_cyc(20);
        // floor 4 dir up, calls {6,1}: serve 6, then reverse down to 1
        ex(SI, 4, 1, 8'h42, 1); ex(SU, 4, 1, 8'h42, 4); ex(SU, 5, 1, 8'h42, 4); ex(SO, 6, 1, 8'h02, 6);
        ex(SC, 6, 1, 8'h02, 1); ex(SI, 6, 1, 8'h02, 1);
        for (int f = 6; f >= 2; f--) ex(SD, f, 0, 8'h02, 4);
        ex(SO, 1, 0, 8'h00, 6); ex(SC, 1, 0, 8'h00, 1); ex(SI, 1, 0, 8'h00, 0);
        pulse(8'h42, 0, 0); wait_cyc(50);
        // down to ground floor
        ex(SI, 1, 0, 8'h01, 1); ex(SD, 1, 0, 8'h01, 4); ex(SO, 0, 0, 8'h00, 6); ex(SC, 0, 0, 8'h00, 1);
        ex(SI, 0, 0, 8'h00, 0);
        pulse(8'h01, 0, 0); wait_cyc(20);
        // floor 0, calls {2,5}: stop at 2 then continue to 5
        ex(SI, 0, 0, 8'h24, 1); ex(SU, 0, 1, 8'h24, 4); ex(SU, 1, 1, 8'h24, 4); ex(SO, 2, 1, 8'h20, 6);
        ex(SC, 2, 1, 8'h20, 1); ex(SI, 2, 1, 8'h20, 1);
        for (int f = 2; f <= 4; f++) ex(SU, f, 1, 8'h20, 4);
        ex(SO, 5, 1, 8'h00, 6); ex(SC, 5, 1, 8'h00, 1); ex(SI, 5, 1, 8'h00, 0);
        pulse(8'h24, 0, 0); wait_cyc(40);
        // down to 2, door_open_btn during CLOSE reopens for a full dwell
        ex(SI, 5, 1, 8'h04, 1);
        for (int f = 5; f >= 3; f--) ex(SD, f, 0, 8'h04, 4);
        ex(SO, 2, 0, 8'h00, 6); ex(SC, 2, 0, 8'h00, 1); ex(SO, 2, 0, 8'h00, 6); ex(SC, 2, 0, 8'h00, 1);
        ex(SI, 2, 0, 8'h00, 0);
        pulse(8'h04, 0, 0); wait_cyc(19); pulse(8'h00, 1, 0); wait_cyc(15);
        // open from IDLE, both buttons after 2 cycles: open wins and restarts dwell
        ex(SO, 2, 0, 8'h00, 8); ex(SC, 2, 0, 8'h00, 1); ex(SI, 2, 0, 8'h00, 0);
        pulse(8'h00, 1, 0); wait_cyc(1); pulse(8'h00, 1, 1); wait_cyc(15);
        // close button cuts dwell short
        ex(SO, 2, 0, 8'h00, 2); ex(SC, 2, 0, 8'h00, 1); ex(SI, 2, 0, 8'h00, 0);
        pulse(8'h00, 1, 0); wait_cyc(1); pulse(8'h00, 0, 1); wait_cyc(10);
        // call for current floor while open: not latched, dwell restarts
        ex(SO, 2, 0, 8'h00, 8); ex(SC, 2, 0, 8'h00, 1); ex(SI, 2, 0, 8'h00, 0);
        pulse(8'h00, 1, 0); wait_cyc(1); pulse(8'h04, 0, 0); wait_cyc(15);
`ifdef ELEV_OVERLOAD_EN
        // overload for 10 cycles mid-dwell extends open by 10, close button ignored
        ex(SO, 2, 0, 8'h00, 16); ex(SC, 2, 0, 8'h00, 1); ex(SI, 2, 0, 8'h00, 0);
        pulse(8'h00, 1, 0); wait_cyc(1);
        overload = 1'b1; door_close_btn = 1'b1;
        wait_cyc(10);
        overload = 1'b0; door_close_btn = 1'b0;
        wait_cyc(15);
`endif
        // down to 1, then reset while travelling 1 -> 3
        ex(SI, 2, 0, 8'h02, 1); ex(SD, 2, 0, 8'h02, 4); ex(SO, 1, 0, 8'h00, 6); ex(SC, 1, 0, 8'h00, 1);
        ex(SI, 1, 0, 8'h00, 0);
        pulse(8'h02, 0, 0); wait_cyc(20);
        ex(SI, 1, 0, 8'h08, 1); ex(SU, 1, 1, 8'h08, 4); ex(SU, 2, 1, 8'h08, 1); ex(SI, 0, 1, 8'h00, 0);
        pulse(8'h08, 0, 0); wait_cyc(6);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(5);
        flush = 1;
        for (int i = 0; i < 10 && !flushed; i++) @(posedge clk);
        checks++;
        if (!flushed || q.size() != 0) begin
            failures++;
            $display("FAIL drain: flushed=%0d queued=%0d, required flushed=1 queued=0", flushed, q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
